// File: rtl/pkt_pkg.sv
// Shared definitions for the DAQ packet framer: header magic, FSM states,
// header field widths and tuser flag positions.
package pkt_pkg;

    localparam logic [15:0] PKT_MAGIC = 16'hA55A;

    localparam int unsigned SEQ_W = 16;
    localparam int unsigned LEN_W = 16;

    // Flag positions measured down from the tuser MSB.
    localparam int unsigned HDR_FLAG_OFS = 1;
    localparam int unsigned PAD_FLAG_OFS = 2;

    typedef enum logic [2:0] {
        IDLE,
        HDR1,
        PAYLOAD,
        PAD,
        CSUM
    } pkt_state_t;

endpackage

// File: rtl/axi_if.sv
// AXI-stream signal bundle with master/slave views.
interface axi_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned USER_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [USER_W-1:0] tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/pkt_timeout_timer.sv
// Starvation timer: counts enabled cycles and pulses expire on the cycle the
// count sits at TIMEOUT-1 while still enabled.
module pkt_timeout_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expire
);
    localparam int unsigned W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] tmo;

    assign expire = count_en && (tmo == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo <= '0;
        end else if (clear || expire) begin
            tmo <= '0;
        end else if (count_en) begin
            tmo <= tmo + W'(1);
        end
    end
endmodule

// File: rtl/axi_packetizer.sv
// Frames 32-bit samples into fixed-length packets (2 headers + PKT_LEN payload),
// zero-padding on starvation or early tlast. Define PKT_CHECKSUM_EN for a sum trailer.
module axi_packetizer
    import pkt_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned USER_W  = 8,
    parameter int unsigned PKT_LEN = 64,
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [7:0]  CH_ID   = 8'h00
) (
    input  logic   clk,
    input  logic   rst,
    axi_if.slave   s_axi_if,
    axi_if.master  m_axi_if
);
    generate
        if (DATA_W != 32 || USER_W < 3 || PKT_LEN < 2 || PKT_LEN > 65535 || TIMEOUT < 2) begin : g_bad_cfg
            $error("axi_packetizer: unsupported parameter set");
        end
    endgenerate

    localparam logic [LEN_W-1:0]  LEN_FIELD = LEN_W'(PKT_LEN);
    localparam logic [15:0]       CNT_LAST  = 16'(PKT_LEN - 1);
    localparam logic [DATA_W-1:0] HDR0      = {PKT_MAGIC, CH_ID, 8'h00};
    localparam logic [USER_W-1:0] HDR_FLAG  = USER_W'(1) << (USER_W - HDR_FLAG_OFS);
    localparam logic [USER_W-1:0] PAD_FLAG  = USER_W'(1) << (USER_W - PAD_FLAG_OFS);

    pkt_state_t        state, nstate;
    logic [SEQ_W-1:0]  seq;
    logic [15:0]       cnt;
    logic [DATA_W-1:0] m_data;
    logic [USER_W-1:0] m_user;
    logic              m_last, m_valid;

    logic              ld, accept, load, ld_last, cnt_inc, cnt_clr, seq_inc;
    logic [DATA_W-1:0] ld_data;
    logic [USER_W-1:0] ld_user;
    logic              tmo_en, tmo_clear, tmo_expire;
    logic              unused_in_flags;

`ifdef PKT_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    assign ld              = !m_valid || m_axi_if.tready;
    assign s_axi_if.tready = (state == PAYLOAD) && ld;
    assign accept          = s_axi_if.tvalid && s_axi_if.tready;
    assign unused_in_flags = ^s_axi_if.tuser[USER_W-1:USER_W-2];

    assign m_axi_if.tdata  = m_data;
    assign m_axi_if.tuser  = m_user;
    assign m_axi_if.tlast  = m_last;
    assign m_axi_if.tvalid = m_valid;

    // Backpressure stalls count as starvation too.
    assign tmo_en    = (state == PAYLOAD) && !accept;
    assign tmo_clear = (state != PAYLOAD) || accept;

    pkt_timeout_timer #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmo_clear),
        .count_en (tmo_en),
        .expire   (tmo_expire)
    );

    always_comb begin
        nstate  = state;
        load    = 1'b0;
        ld_data = '0;
        ld_user = '0;
        ld_last = 1'b0;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        seq_inc = 1'b0;
        case (state)
            IDLE: begin
                if (s_axi_if.tvalid && ld) begin
                    load    = 1'b1;
                    ld_data = HDR0;
                    ld_user = HDR_FLAG;
                    cnt_clr = 1'b1;
                    nstate  = HDR1;
                end
            end
            HDR1: begin
                if (ld) begin
                    load    = 1'b1;
                    ld_data = {seq, LEN_FIELD};
                    ld_user = HDR_FLAG;
                    nstate  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    load    = 1'b1;
                    ld_data = s_axi_if.tdata;
                    ld_user = {2'b00, s_axi_if.tuser[USER_W-3:0]};
                    cnt_inc = 1'b1;
                    if (cnt == CNT_LAST) begin
`ifdef PKT_CHECKSUM_EN
                        nstate  = CSUM;
`else
                        ld_last = 1'b1;
                        seq_inc = 1'b1;
                        nstate  = IDLE;
`endif
                    end else if (s_axi_if.tlast) begin
                        nstate = PAD;
                    end
                end else if (tmo_expire) begin
                    nstate = PAD;
                end
            end
            PAD: begin
                if (ld) begin
                    load    = 1'b1;
                    ld_user = PAD_FLAG;
                    cnt_inc = 1'b1;
                    if (cnt == CNT_LAST) begin
`ifdef PKT_CHECKSUM_EN
                        nstate  = CSUM;
`else
                        ld_last = 1'b1;
                        seq_inc = 1'b1;
                        nstate  = IDLE;
`endif
                    end
                end
            end
            CSUM: begin
`ifdef PKT_CHECKSUM_EN
                if (ld) begin
                    load    = 1'b1;
                    ld_data = csum;
                    ld_user = HDR_FLAG | PAD_FLAG;
                    ld_last = 1'b1;
                    seq_inc = 1'b1;
                    nstate  = IDLE;
                end
`else
                nstate = IDLE;
`endif
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            seq     <= '0;
            cnt     <= '0;
            m_data  <= '0;
            m_user  <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            state <= nstate;
            if (load) begin
                m_valid <= 1'b1;
                m_data  <= ld_data;
                m_user  <= ld_user;
                m_last  <= ld_last;
            end else if (m_axi_if.tready) begin
                m_valid <= 1'b0;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 16'd1;
            end
            if (seq_inc) begin
                seq <= seq + SEQ_W'(1);
            end
        end
    end

`ifdef PKT_CHECKSUM_EN
    // Header 0 restarts the sum; every later word of the packet accumulates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else if (load && state == IDLE) begin
            csum <= ld_data;
        end else if (load) begin
            csum <= csum + ld_data;
        end
    end
`endif

endmodule

// File: tb/tb_axi_packetizer.sv
// Directed bench for axi_packetizer with PKT_LEN=4, TIMEOUT=8, CH_ID=3.
module tb_axi_packetizer;
    localparam int unsigned PLEN = 4;
`ifdef PKT_CHECKSUM_EN
    localparam int unsigned NWORDS = PLEN + 3;
`else
    localparam int unsigned NWORDS = PLEN + 2;
`endif

    typedef struct packed {
        logic        last;
        logic [7:0]  user;
        logic [31:0] data;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    axi_if #(.DATA_W(32), .USER_W(8)) s_if ();
    axi_if #(.DATA_W(32), .USER_W(8)) m_if ();

    axi_packetizer #(
        .DATA_W  (32),
        .USER_W  (8),
        .PKT_LEN (PLEN),
        .TIMEOUT (8),
        .CH_ID   (8'd3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_axi_if (s_if),
        .m_axi_if (m_if)
    );

    always #5 clk = ~clk;

    int        passed = 0;
    int        total  = 0;
    word_t     outq[$];
    logic      rdy_log[$];
    logic      in_acc;
    logic      pend = 1'b0;
    logic [41:0] held;
    logic [31:0] pat = 32'hB4D2_6C39;
    int        cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One cycle: sample just after the falling edge, then advance to the next falling edge.
    task automatic tick();
        #1;
        if (pend)
            check("stall_hold", {22'd0, m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata}, {22'd0, held});
        pend = m_if.tvalid && !m_if.tready;
        held = {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata};
        if (m_if.tvalid && m_if.tready)
            outq.push_back(word_t'{m_if.tlast, m_if.tuser, m_if.tdata});
        rdy_log.push_back(s_if.tready);
        in_acc = s_if.tvalid && s_if.tready;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ready(input bit rnd);
        m_if.tready = rnd ? pat[cyc % 32] : 1'b1;
    endtask

    task automatic stream(input string tag, input int n, input int first, input int last_at, input bit rnd);
        int idx = 0;
        int c = 0;
        logic [31:0] v;
        while (idx < n && c < 300) begin
            v = 32'(first + idx);
            s_if.tvalid = 1'b1;
            s_if.tdata  = v;
            s_if.tlast  = (idx == last_at);
            s_if.tuser  = 8'hC0 | {2'b00, v[5:0]};
            set_ready(rnd);
            tick();
            if (in_acc) idx++;
            c++;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        check({tag, "_accepted"}, 64'(idx), 64'(n));
    endtask

    task automatic drain(input string tag, input int n, input bit rnd);
        int c = 0;
        while (outq.size() < n && c < 300) begin
            set_ready(rnd);
            tick();
            c++;
        end
        m_if.tready = 1'b1;
        check({tag, "_drain"}, 64'(outq.size()), 64'(n));
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic [7:0] u, input logic l);
        word_t w;
        if (outq.size() == 0) begin
            check({tag, "_missing"}, 64'd0, 64'd1);
        end else begin
            w = outq.pop_front();
            check(tag, {23'd0, w.last, w.user, w.data}, {23'd0, l, u, d});
        end
    endtask

    task automatic expect_packet(input string tag, input logic [15:0] sq, input int first, input int n_real);
        logic [31:0] d, sum, v;
        logic [7:0]  u;
        logic        l;
        sum = '0;
        for (int i = 0; i < int'(NWORDS); i++) begin
            l = 1'b0;
            if (i == 0) begin
                d = 32'hA55A0300; u = 8'h80;
            end else if (i == 1) begin
                d = {sq, 16'd4}; u = 8'h80;
            end else if (i < 2 + n_real) begin
                v = 32'(first + i - 2);
                d = v; u = {2'b00, v[5:0]};
            end else if (i < 2 + int'(PLEN)) begin
                d = '0; u = 8'h40;
            end else begin
                d = sum; u = 8'hC0; l = 1'b1;
            end
`ifndef PKT_CHECKSUM_EN
            l = (i == int'(PLEN) + 1);
`endif
            if (i < 2 + int'(PLEN)) sum = sum + d;
            expect_word($sformatf("%s_w%0d", tag, i), d, u, l);
        end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = '0;
        m_if.tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_tdata",  64'(m_if.tdata),  64'd0);
        check("rst_tlast",  64'(m_if.tlast),  64'd0);
        check("rst_tuser",  64'(m_if.tuser),  64'd0);
        check("rst_tready", 64'(s_if.tready), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back samples 1..8: two full packets, seq 0 and 1.
        rdy_log.delete();
        stream("b2b", 8, 1, -1, 1'b0);
        check("rdy_idle",    64'(rdy_log[0]), 64'd0);
        check("rdy_hdr1",    64'(rdy_log[1]), 64'd0);
        check("rdy_payload", 64'(rdy_log[2]), 64'd1);
        check("rdy_next_hdr", 64'(rdy_log[6]), 64'd0);
        drain("b2b", 2 * NWORDS, 1'b0);
        expect_packet("b2b_p0", 16'd0, 1, 4);
        expect_packet("b2b_p1", 16'd1, 5, 4);
`ifdef PKT_CHECKSUM_EN
        check("csum_1to4_const", 64'(32'hA55A0300 + 32'h4 + 32'd10), 64'(32'hA55A030E));
`endif

        // Starvation: two samples, then padding after exactly eight idle payload cycles.
        stream("tmo", 2, 1, -1, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        check("tmo_not_early", 64'(outq.size()), 64'd4);
        tick();
        check("tmo_pad_start", 64'(outq.size()), 64'd5);
        drain("tmo", NWORDS, 1'b0);
        expect_packet("tmo", 16'd2, 1, 2);

        // Early upstream tlast on the first payload word.
        stream("elast", 1, 9, 0, 1'b0);
        drain("elast", NWORDS, 1'b0);
        expect_packet("elast", 16'd3, 9, 1);

        // Downstream backpressure pattern over samples 1..12.
        stream("stall", 12, 1, -1, 1'b1);
        drain("stall", 3 * NWORDS, 1'b1);
        expect_packet("stall_p0", 16'd4, 1, 4);
        expect_packet("stall_p1", 16'd5, 5, 4);
        expect_packet("stall_p2", 16'd6, 9, 4);

        // Asynchronous reset with word 2 sitting in the output register.
        stream("rst", 2, 1, -1, 1'b0);
        expect_word("rst_w0", 32'hA55A0300, 8'h80, 1'b0);
        expect_word("rst_w1", 32'h00070004, 8'h80, 1'b0);
        expect_word("rst_w2", 32'h00000001, 8'h01, 1'b0);
        check("pre_rst_tvalid", 64'(m_if.tvalid), 64'd1);
        check("pre_rst_tdata",  64'(m_if.tdata),  64'd2);
        rst = 1'b1;
        #1;
        check("rst_async_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_async_tdata",  64'(m_if.tdata),  64'd0);
        @(negedge clk);
        rst  = 1'b0;
        pend = 1'b0;
        outq.delete();
        @(negedge clk);
        stream("post_rst", 1, 5, -1, 1'b0);
        drain("post_rst", NWORDS, 1'b0);
        expect_packet("post_rst", 16'd0, 5, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
